unit_cmd_sequencer: RTL
=======================

Name: unit_cmd_sequencer

Overview:
Command-driven sequencer for the compute unit (FP16 ALU array plus tensorcore).
- Accepts one vector command at a time: opmode, three operand base addresses, destination base address, length.
- Streams operand reads from the A/B/C BRAMs into the unit and writes unit results to the result BRAM.
- Holds opmode stable until every result of the command has been written back, then pulses done.
- Sits between the host/command interface and the unit plus its four 288-bit x 1024 BRAMs.

Parameters:
ADDR_W, 10, BRAM address width; all address arithmetic wraps mod 2^ADDR_W
LEN_W, 11, command length width; allows 0..1024 vectors
BRAM_LAT, 1, BRAM read latency in cycles, from address register to rdata valid
TIMEOUT, 255, max consecutive DRAIN cycles without unit_out_valid before abort

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_opmode  in  8  unit opmode; bit7 selects tensorcore, bit6 selects e5m2, [5:0] selects ALU op
cmd_a_addr / cmd_b_addr / cmd_c_addr  in  ADDR_W each  operand base addresses
cmd_dst_addr  in  ADDR_W  result base address
cmd_len  in  LEN_W  number of 256-bit vectors
rd_a_addr / rd_b_addr / rd_c_addr  out  ADDR_W each  operand BRAM read addresses (registered)
unit_in_valid  out  1  operand valid to unit
unit_opmode  out  8  opmode to unit
unit_out  in  256  unit result
unit_out_valid  in  1  unit result valid
wr_addr  out  ADDR_W  result BRAM address
wr_data  out  288  {32'b0, unit_out}
wr_we  out  36  byte enables; all ones or all zeros
busy  out  1  high when state is not IDLE
done  out  1  one-cycle pulse at end of command
err_timeout  out  1  sticky; set by a DRAIN timeout
err_spurious  out  1  sticky; set by an unexpected unit_out_valid

Behaviour:
- Reset values: every output 0, except cmd_ready = 1. State = IDLE; all counters = 0; delay line cleared.
- Reset mid-command: the command is abandoned and in-flight results are discarded.
- States: IDLE, ISSUE, DRAIN, DONE.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid & cmd_ready in cycle N: latch all fields; unit_opmode takes cmd_opmode at N+1; clear both error flags; issue count i = 0; write count w = 0.
  - If cmd_len == 0: go to DONE (no reads, no writes). Otherwise go to ISSUE.
  - cmd_ready is low in every other state.
- ISSUE:
  - Each cycle: rd_*_addr = base_* + i, then i increments.
  - A BRAM_LAT-deep delay line generates unit_in_valid exactly BRAM_LAT cycles after each issued address.
  - First address appears at N+1; first unit_in_valid at N+1+BRAM_LAT.
  - When i == len-1 has been issued, go to DRAIN.
  - Once the delay line empties, rd addresses hold their last value.
- DRAIN:
  - unit_in_valid continues until the delay line empties, then is 0.
  - Leave DRAIN for DONE when w == len.
  - Watchdog counts consecutive cycles with no unit_out_valid and resets on each valid. Reaching TIMEOUT sets err_timeout and forces DONE.
- Writeback (ISSUE or DRAIN, while w < len):
  - unit_out_valid in cycle M causes, at M+1: wr_addr = dst + w, wr_data = {32'b0, unit_out}, wr_we = 36'hF_FFFF_FFFF. w then increments.
  - wr_we returns to 0 in the next cycle with no valid.
  - Back-to-back valids produce back-to-back writes.
- Spurious results: unit_out_valid in IDLE or DONE, or with w == len, is not written and sets err_spurious.
- DONE:
  - done = 1 for exactly one cycle, then IDLE.
  - cmd_ready rises in the cycle after done.
- unit_opmode is constant from cycle N+1 until the next accepted command. It never changes while results are in flight.
- Addresses wrap: a base of 1023 with i = 1 gives 0.
- Length 1024 is legal: exactly 1024 writes.

Test Plan:
- Single command, opmode=8'h00, a/b/c=0, dst=0, len=4, unit modelled as a 3-cycle pipe -> rd addresses 0,1,2,3 on consecutive cycles; 4 writes at wr_addr 0..3 with wr_data[287:256]=0; one done pulse; busy falls with done.
- len=0 with cmd_valid -> done pulses at N+2; no rd address change, no wr_we, no unit_in_valid.
- Tensorcore command opmode=8'h80, a=1022, dst=1023, len=3 -> rd_a 1022,1023,0; wr_addr 1023,0,1; unit_opmode stays 8'h80 through the last write.
- Back-to-back commands with cmd_valid held high -> cmd_ready=0 while busy; second command accepted the cycle after done; no write interleaving between the two commands.
- Unit model drops the last result, len=2, TIMEOUT=255 -> one write; err_timeout=1 after 255 idle DRAIN cycles; done pulses; next command clears err_timeout.
- rst low during ISSUE with len=16 -> all outputs 0 and cmd_ready=1 immediately. Stray unit_out_valid after release -> err_spurious=1, wr_we stays 0.

Source files
------------

// File: rtl/unit_cmd_sequencer.sv
// Command sequencer for the FP16 ALU array / tensorcore: streams operand reads from the
// A/B/C BRAMs, writes unit results to the result BRAM, then pulses done.
module unit_cmd_sequencer #(
  parameter int unsigned ADDR_W   = 10,
  parameter int unsigned LEN_W    = 11,
  parameter int unsigned BRAM_LAT = 1,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [7:0]        cmd_opmode,
  input  logic [ADDR_W-1:0] cmd_a_addr,
  input  logic [ADDR_W-1:0] cmd_b_addr,
  input  logic [ADDR_W-1:0] cmd_c_addr,
  input  logic [ADDR_W-1:0] cmd_dst_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic [ADDR_W-1:0] rd_a_addr,
  output logic [ADDR_W-1:0] rd_b_addr,
  output logic [ADDR_W-1:0] rd_c_addr,
  output logic              unit_in_valid,
  output logic [7:0]        unit_opmode,
  input  logic [255:0]      unit_out,
  input  logic              unit_out_valid,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [287:0]      wr_data,
  output logic [35:0]       wr_we,
  output logic              busy,
  output logic              done,
  output logic              err_timeout,
  output logic              err_spurious
);

  localparam int unsigned WdW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e              state_q, state_d;
  logic [7:0]          opmode_q, opmode_d;
  logic [ADDR_W-1:0]   a_base_q, a_base_d;
  logic [ADDR_W-1:0]   b_base_q, b_base_d;
  logic [ADDR_W-1:0]   c_base_q, c_base_d;
  logic [ADDR_W-1:0]   dst_base_q, dst_base_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic [LEN_W-1:0]    i_q, i_d;
  logic [LEN_W-1:0]    w_q, w_d;
  logic [ADDR_W-1:0]   rd_a_q, rd_a_d;
  logic [ADDR_W-1:0]   rd_b_q, rd_b_d;
  logic [ADDR_W-1:0]   rd_c_q, rd_c_d;
  logic [BRAM_LAT-1:0] vld_q, vld_d;
  logic [WdW-1:0]      wd_q, wd_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [255:0]        wr_data_q, wr_data_d;
  logic                wr_we_q, wr_we_d;
  logic                done_q, done_d;
  logic                err_timeout_q, err_timeout_d;
  logic                err_spurious_q, err_spurious_d;

  logic                accept;
  logic                issue_now;
  logic                wb_open;
  logic [LEN_W-1:0]    i_inc;
  logic [WdW-1:0]      wd_inc;

  // Ready is withheld during the done pulse so a held cmd_valid is taken the cycle after it.
  assign cmd_ready     = (state_q == StIdle) && !done_q;
  assign accept        = cmd_valid && cmd_ready;
  assign issue_now     = (state_q == StIssue);
  assign wb_open       = ((state_q == StIssue) || (state_q == StDrain)) && (w_q != len_q);
  assign i_inc         = i_q + LEN_W'(1);
  assign wd_inc        = wd_q + WdW'(1);

  assign rd_a_addr     = rd_a_q;
  assign rd_b_addr     = rd_b_q;
  assign rd_c_addr     = rd_c_q;
  assign unit_in_valid = vld_q[BRAM_LAT-1];
  assign unit_opmode   = opmode_q;
  assign wr_addr       = wr_addr_q;
  assign wr_data       = {32'b0, wr_data_q};
  assign wr_we         = {36{wr_we_q}};
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign err_timeout   = err_timeout_q;
  assign err_spurious  = err_spurious_q;

  // Bit k is high when an address issued k+1 cycles ago is being read.
  assign vld_d = BRAM_LAT'({vld_q, issue_now});

  always_comb begin
    state_d        = state_q;
    opmode_d       = opmode_q;
    a_base_d       = a_base_q;
    b_base_d       = b_base_q;
    c_base_d       = c_base_q;
    dst_base_d     = dst_base_q;
    len_d          = len_q;
    i_d            = i_q;
    w_d            = w_q;
    rd_a_d         = rd_a_q;
    rd_b_d         = rd_b_q;
    rd_c_d         = rd_c_q;
    wd_d           = wd_q;
    wr_addr_d      = wr_addr_q;
    wr_data_d      = wr_data_q;
    wr_we_d        = 1'b0;
    done_d         = 1'b0;
    err_timeout_d  = err_timeout_q;
    err_spurious_d = err_spurious_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          opmode_d       = cmd_opmode;
          a_base_d       = cmd_a_addr;
          b_base_d       = cmd_b_addr;
          c_base_d       = cmd_c_addr;
          dst_base_d     = cmd_dst_addr;
          len_d          = cmd_len;
          i_d            = '0;
          w_d            = '0;
          wd_d           = '0;
          err_timeout_d  = 1'b0;
          err_spurious_d = 1'b0;
          if (cmd_len == '0) begin
            state_d = StDone;
          end else begin
            rd_a_d  = cmd_a_addr;
            rd_b_d  = cmd_b_addr;
            rd_c_d  = cmd_c_addr;
            state_d = StIssue;
          end
        end
      end
      StIssue: begin
        if (i_q == len_q - LEN_W'(1)) begin
          wd_d    = '0;
          state_d = StDrain;
        end else begin
          i_d    = i_inc;
          rd_a_d = a_base_q + ADDR_W'(i_inc);
          rd_b_d = b_base_q + ADDR_W'(i_inc);
          rd_c_d = c_base_q + ADDR_W'(i_inc);
        end
      end
      StDrain: begin
        if (w_q == len_q) begin
          state_d = StDone;
        end else if (unit_out_valid) begin
          wd_d = '0;
        end else if (wd_inc == WdW'(TIMEOUT)) begin
          err_timeout_d = 1'b1;
          state_d       = StDone;
        end else begin
          wd_d = wd_inc;
        end
      end
      StDone: begin
        done_d  = 1'b1;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Results outside an open command window are dropped and flagged.
    if (unit_out_valid) begin
      if (wb_open) begin
        wr_addr_d = dst_base_q + ADDR_W'(w_q);
        wr_data_d = unit_out;
        wr_we_d   = 1'b1;
        w_d       = w_q + LEN_W'(1);
      end else begin
        err_spurious_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= StIdle;
      opmode_q       <= '0;
      a_base_q       <= '0;
      b_base_q       <= '0;
      c_base_q       <= '0;
      dst_base_q     <= '0;
      len_q          <= '0;
      i_q            <= '0;
      w_q            <= '0;
      rd_a_q         <= '0;
      rd_b_q         <= '0;
      rd_c_q         <= '0;
      vld_q          <= '0;
      wd_q           <= '0;
      wr_addr_q      <= '0;
      wr_data_q      <= '0;
      wr_we_q        <= 1'b0;
      done_q         <= 1'b0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      opmode_q       <= opmode_d;
      a_base_q       <= a_base_d;
      b_base_q       <= b_base_d;
      c_base_q       <= c_base_d;
      dst_base_q     <= dst_base_d;
      len_q          <= len_d;
      i_q            <= i_d;
      w_q            <= w_d;
      rd_a_q         <= rd_a_d;
      rd_b_q         <= rd_b_d;
      rd_c_q         <= rd_c_d;
      vld_q          <= vld_d;
      wd_q           <= wd_d;
      wr_addr_q      <= wr_addr_d;
      wr_data_q      <= wr_data_d;
      wr_we_q        <= wr_we_d;
      done_q         <= done_d;
      err_timeout_q  <= err_timeout_d;
      err_spurious_q <= err_spurious_d;
    end
  end

endmodule
